// File: rtl/bin_peak_hold_if.sv
// bin_peak_hold_if: complex-bin input handshake, clear request and BRAM write port
interface bin_peak_hold_if #(
  parameter int FREQ_W     = 9,
  parameter int BIN_ADDR_W = 5,
  parameter int OUT_W      = 10
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [FREQ_W-1:0]     in_real;
  logic signed [FREQ_W-1:0]     in_imag;
  logic        [BIN_ADDR_W-1:0] in_addr;
  logic                         clear;
  logic                         out_w_en;
  logic        [BIN_ADDR_W-1:0] out_w_addr;
  logic        [OUT_W-1:0]      out_w_data;
  modport master (
    output in_valid, in_real, in_imag, in_addr, clear,
    input  in_ready, out_w_en, out_w_addr, out_w_data
  );
  modport slave (
    input  in_valid, in_real, in_imag, in_addr, clear,
    output in_ready, out_w_en, out_w_addr, out_w_data
  );
endinterface

// File: rtl/bin_peak_hold.sv
// bin_peak_hold: bin power via one shared multiplier, scale/saturate, per-bin peak hold with linear decay
module bin_peak_hold #(
  parameter int FREQ_W     = 9,
  parameter int FREQ_BINS  = 32,
  parameter int BIN_ADDR_W = 5,
  parameter int OUT_W      = 10,
  parameter int SHIFT      = 6,
  parameter int DECAY_STEP = 4
) (
  input logic             clk,
  input logic             reset,
  bin_peak_hold_if.slave  s_bus
);
  localparam int CW = $clog2(FREQ_BINS);
  localparam logic [BIN_ADDR_W:0] NB = (BIN_ADDR_W+1)'(FREQ_BINS);
  localparam logic [OUT_W-1:0] DEC = OUT_W'(DECAY_STEP);
  typedef enum logic [2:0] {CLEAR, IDLE, SQ_RE, SQ_IM, SCALE, HOLD} state_t;
  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic                     r_pend;
  logic signed [FREQ_W-1:0] r_re, r_im;
  logic [BIN_ADDR_W-1:0]    r_addr;
  logic [2*FREQ_W-1:0]      r_acc;
  logic [OUT_W-1:0]         r_p, r_held;
  logic                     r_out_en;
  logic [BIN_ADDR_W-1:0]    r_out_addr;
  logic [OUT_W-1:0]         r_out_data;
  logic [OUT_W-1:0]         r_mem [FREQ_BINS];
  logic signed [FREQ_W-1:0]   w_op;
  logic signed [2*FREQ_W-1:0] w_sq;
  logic [2*FREQ_W-1:0]        w_shr;
  logic [OUT_W-1:0]           w_sat, w_dec, w_h, w_wdata;
  logic                       w_in_range, w_we;
  logic [CW-1:0]              w_widx;
  // one multiplier serves both squares; the operand follows the state
  assign w_op       = r_state == SQ_RE ? r_re : r_im;
  assign w_sq       = w_op * w_op;
  assign w_shr      = r_acc >> SHIFT;
  assign w_sat      = |w_shr[2*FREQ_W-1:OUT_W] ? '1 : w_shr[OUT_W-1:0];
  assign w_dec      = r_held >= DEC ? r_held - DEC : '0;
  assign w_h        = r_p >= r_held ? r_p : (r_p > w_dec ? r_p : w_dec);
  assign w_in_range = {1'b0, r_addr} < NB;
  assign w_we       = r_state == CLEAR || (r_state == HOLD && w_in_range);
  assign w_widx     = r_state == CLEAR ? r_cnt : CW'(r_addr);
  assign w_wdata    = r_state == CLEAR ? '0 : w_h;
  assign s_bus.in_ready   = r_state == IDLE;
  assign s_bus.out_w_en   = r_out_en;
  assign s_bus.out_w_addr = r_out_addr;
  assign s_bus.out_w_data = r_out_data;
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= w_wdata;
    if (r_state == SQ_RE) r_held <= r_mem[CW'(r_addr)];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_re       <= '0;
      r_im       <= '0;
      r_addr     <= '0;
      r_acc      <= '0;
      r_p        <= '0;
      r_out_en   <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_out_en <= 1'b0;
      if (s_bus.clear && r_state != CLEAR && r_state != IDLE) r_pend <= 1'b1;
      case (r_state)
        CLEAR: begin
          r_out_en   <= 1'b1;
          r_out_addr <= BIN_ADDR_W'(r_cnt);
          r_out_data <= '0;
          r_cnt      <= r_cnt == CW'(FREQ_BINS-1) ? '0 : r_cnt + 1'b1;
          if (r_cnt == CW'(FREQ_BINS-1)) r_state <= IDLE;
        end
        IDLE: begin
          if (r_pend || s_bus.clear) begin
            r_pend  <= 1'b0;
            r_state <= CLEAR;
          end else if (s_bus.in_valid) begin
            r_re    <= s_bus.in_real;
            r_im    <= s_bus.in_imag;
            r_addr  <= s_bus.in_addr;
            r_state <= SQ_RE;
          end
        end
        SQ_RE: begin
          r_acc   <= w_sq;
          r_state <= SQ_IM;
        end
        SQ_IM: begin
          r_acc   <= r_acc + w_sq;
          r_state <= SCALE;
        end
        SCALE: begin
          r_p     <= w_sat;
          r_state <= HOLD;
        end
        HOLD: begin
          if (w_in_range) begin
            r_out_en   <= 1'b1;
            r_out_addr <= r_addr;
            r_out_data <= w_h;
          end
          r_state <= IDLE;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_peak_hold.sv
// tb_bin_peak_hold: directed tests for sweep, power, saturation, decay, range, clear and async reset
module tb_bin_peak_hold;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  bin_peak_hold_if #(.FREQ_W(9), .BIN_ADDR_W(6), .OUT_W(10)) bus();
  bin_peak_hold #(
    .FREQ_W(9), .FREQ_BINS(32), .BIN_ADDR_W(6), .OUT_W(10), .SHIFT(6), .DECAY_STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_bus(bus)
  );
  always #5 clk = ~clk;
  task automatic send(input int re, input int im, input int addr);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL send_ready got=%b want=1", bus.in_ready); end
    bus.in_real  = 9'(re);
    bus.in_imag  = 9'(im);
    bus.in_addr  = 6'(addr);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_strobe(output int lat);
    lat = 1;
    while (bus.out_w_en !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    bus.in_real = '0; bus.in_imag = '0; bus.in_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.out_w_en, bus.in_ready, bus.out_w_addr, bus.out_w_data} !== 18'd0) begin failures++; $display("FAIL reset_state got=%b%b %0d %0d want=00 0 0", bus.out_w_en, bus.in_ready, bus.out_w_addr, bus.out_w_data); end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++; if ({bus.out_w_en, bus.out_w_addr, bus.out_w_data} !== {1'b1, 6'(i), 10'd0}) begin failures++; $display("FAIL reset_sweep i=%0d got=%b %0d %0d want=1 %0d 0", i, bus.out_w_en, bus.out_w_addr, bus.out_w_data, i); end
      if (i < 31) begin checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_sweep_ready i=%0d got=%b want=0", i, bus.in_ready); end end
    end
    @(negedge clk);
    checks++; if ({bus.out_w_en, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL reset_done got=%b%b want=01", bus.out_w_en, bus.in_ready); end
  endtask
  task automatic test_power;
    int lat;
    send(16, -16, 3);
    wait_strobe(lat);
    checks++; if (lat !== 5) begin failures++; $display("FAIL power_lat got=%0d want=5", lat); end
    checks++; if (bus.out_w_addr !== 6'd3) begin failures++; $display("FAIL power_addr got=%0d want=3", bus.out_w_addr); end
    checks++; if (bus.out_w_data !== 10'd8) begin failures++; $display("FAIL power_data got=%0d want=8", bus.out_w_data); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL power_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_w_en !== 1'b0) begin failures++; $display("FAIL power_single got=%b want=0", bus.out_w_en); end
    checks++; if ({bus.out_w_addr, bus.out_w_data} !== {6'd3, 10'd8}) begin failures++; $display("FAIL power_hold got=%0d %0d want=3 8", bus.out_w_addr, bus.out_w_data); end
  endtask
  task automatic test_saturate;
    int lat;
    send(-256, -256, 0);
    wait_strobe(lat);
    checks++; if ({bus.out_w_addr, bus.out_w_data} !== {6'd0, 10'd1023} || lat !== 5) begin failures++; $display("FAIL saturate got=%0d %0d lat=%0d want=0 1023 lat=5", bus.out_w_addr, bus.out_w_data, lat); end
    @(negedge clk);
  endtask
  task automatic test_decay;
    int re_t[5]  = '{80, 0, 0, 64, 96};
    int exp_t[5] = '{100, 96, 92, 88, 144};
    int lat;
    for (int i = 0; i < 5; i++) begin
      send(re_t[i], 0, 5);
      wait_strobe(lat);
      checks++; if (bus.out_w_data !== 10'(exp_t[i]) || bus.out_w_addr !== 6'd5 || lat !== 5) begin failures++; $display("FAIL decay step=%0d got=%0d addr=%0d lat=%0d want=%0d addr=5 lat=5", i, bus.out_w_data, bus.out_w_addr, lat, exp_t[i]); end
    end
    @(negedge clk);
  endtask
  task automatic test_out_of_range;
    int seen = 0;
    int lat;
    send(200, 0, 40);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (bus.out_w_en === 1'b1) seen++;
      if (k == 4) begin checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL range_busy got=%b want=0", bus.in_ready); end end
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL range_no_strobe got=%0d want=0", seen); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL range_ready got=%b want=1", bus.in_ready); end
    send(40, 0, 8);
    wait_strobe(lat);
    checks++; if ({bus.out_w_addr, bus.out_w_data} !== {6'd8, 10'd25} || lat !== 5) begin failures++; $display("FAIL range_next got=%0d %0d lat=%0d want=8 25 lat=5", bus.out_w_addr, bus.out_w_data, lat); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int lat;
    send(32, 0, 10);
    wait_strobe(lat);
    checks++; if (bus.out_w_data !== 10'd16 || lat !== 5) begin failures++; $display("FAIL b2b_first got=%0d lat=%0d want=16 lat=5", bus.out_w_data, lat); end
    send(0, 0, 10);
    wait_strobe(lat);
    checks++; if ({bus.out_w_addr, bus.out_w_data} !== {6'd10, 10'd12} || lat !== 5) begin failures++; $display("FAIL b2b_second got=%0d %0d lat=%0d want=10 12 lat=5", bus.out_w_addr, bus.out_w_data, lat); end
    @(negedge clk);
  endtask
  task automatic test_clear_pending;
    int lat;
    int n = 0;
    send(64, 0, 7);
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    wait_strobe(lat);
    checks++; if ({bus.out_w_addr, bus.out_w_data} !== {6'd7, 10'd64} || lat !== 3) begin failures++; $display("FAIL clear_inflight got=%0d %0d lat=%0d want=7 64 lat=3", bus.out_w_addr, bus.out_w_data, lat); end
    @(negedge clk);
    while (bus.out_w_en !== 1'b1 && n < 3) begin @(negedge clk); n++; end
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if ({bus.out_w_en, bus.out_w_addr, bus.out_w_data} !== {1'b1, 6'(i), 10'd0}) begin failures++; $display("FAIL clear_sweep i=%0d got=%b %0d %0d want=1 %0d 0", i, bus.out_w_en, bus.out_w_addr, bus.out_w_data, i); end
    end
    @(negedge clk);
    checks++; if ({bus.out_w_en, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL clear_done got=%b%b want=01", bus.out_w_en, bus.in_ready); end
    send(0, 0, 5);
    wait_strobe(lat);
    checks++; if ({bus.out_w_addr, bus.out_w_data} !== {6'd5, 10'd0}) begin failures++; $display("FAIL clear_zeroed got=%0d %0d want=5 0", bus.out_w_addr, bus.out_w_data); end
    @(negedge clk);
  endtask
  task automatic test_clear_with_valid;
    int seen = 0;
    bus.clear = 1'b1;
    bus.in_real = 9'd100; bus.in_imag = 9'd0; bus.in_addr = 6'd4;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if ({bus.out_w_en, bus.in_ready} !== 2'b00) begin failures++; $display("FAIL clrv_drop got=%b%b want=00", bus.out_w_en, bus.in_ready); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++; if ({bus.out_w_en, bus.out_w_addr, bus.out_w_data} !== {1'b1, 6'(i), 10'd0}) begin failures++; $display("FAIL clrv_sweep i=%0d got=%b %0d %0d want=1 %0d 0", i, bus.out_w_en, bus.out_w_addr, bus.out_w_data, i); end
    end
    repeat (8) begin @(negedge clk); if (bus.out_w_en === 1'b1) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL clrv_not_accepted got=%0d want=0", seen); end
  endtask
  task automatic test_async_reset;
    int lat;
    send(64, 0, 9);
    wait_strobe(lat);
    checks++; if ({bus.out_w_addr, bus.out_w_data} !== {6'd9, 10'd64}) begin failures++; $display("FAIL areset_pre got=%0d %0d want=9 64", bus.out_w_addr, bus.out_w_data); end
    @(negedge clk);
    send(64, 64, 2);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if ({bus.out_w_en, bus.in_ready, bus.out_w_addr, bus.out_w_data} !== 18'd0) begin failures++; $display("FAIL areset_async got=%b%b %0d %0d want=00 0 0", bus.out_w_en, bus.in_ready, bus.out_w_addr, bus.out_w_data); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++; if ({bus.out_w_en, bus.out_w_addr, bus.out_w_data} !== {1'b1, 6'(i), 10'd0}) begin failures++; $display("FAIL areset_sweep i=%0d got=%b %0d %0d want=1 %0d 0", i, bus.out_w_en, bus.out_w_addr, bus.out_w_data, i); end
      if (i < 31) begin checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL areset_ready i=%0d got=%b want=0", i, bus.in_ready); end end
    end
    @(negedge clk);
    checks++; if ({bus.out_w_en, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL areset_done got=%b%b want=01", bus.out_w_en, bus.in_ready); end
    send(0, 0, 9);
    wait_strobe(lat);
    checks++; if ({bus.out_w_addr, bus.out_w_data} !== {6'd9, 10'd0} || lat !== 5) begin failures++; $display("FAIL areset_zeroed got=%0d %0d lat=%0d want=9 0 lat=5", bus.out_w_addr, bus.out_w_data, lat); end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_power();
    test_saturate();
    test_decay();
    test_out_of_range();
    test_back_to_back();
    test_clear_pending();
    test_clear_with_valid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
